// File: rtl/atpg_pattern_sequencer_if.sv
// ---------------------------------------------------------------------------
// atpg_pattern_sequencer_if
//   Bundles everything between the pattern sequencer and its surroundings:
//   the run control (start), the pattern-memory write bus, the drive/observe
//   pair towards injection_module (dut_in / dut_y) and the result signals.
//
//   master : controller / bench side (drives start, pattern writes, dut_y)
//   slave  : atpg_pattern_sequencer
//
//   Signals
//     start        run request, sampled only while the sequencer is idle/done
//     pat_we       pattern write enable, ignored while busy
//     pat_waddr    pattern write address
//     pat_v1       initialisation vector {a,b,e,f}
//     pat_v2       launch vector {a,b,e,f}
//     pat_exp      expected y for the pattern
//     dut_in       vector driven into injection_module
//     dut_y        response from injection_module
//     busy / done  run in progress / run complete (done held)
//     pat_idx      pattern being applied or last sampled
//     sample_valid one-cycle strobe qualifying sample_y and mismatch
//     sample_y     captured dut_y
//     mismatch     sample_y differs from expected
//     fail_count   mismatching patterns in the current run
//     any_fail     fail_count is nonzero
//     state_dbg    current sequencer state, for observation only
// ---------------------------------------------------------------------------
interface atpg_pattern_sequencer_if #(
    parameter int IN_W   = 4,
    parameter int PAT_AW = 2,
    parameter int CNT_W  = 3
);
    logic              start;
    logic              pat_we;
    logic [PAT_AW-1:0] pat_waddr;
    logic [IN_W-1:0]   pat_v1;
    logic [IN_W-1:0]   pat_v2;
    logic              pat_exp;
    logic [IN_W-1:0]   dut_in;
    logic              dut_y;
    logic              busy;
    logic              done;
    logic [PAT_AW-1:0] pat_idx;
    logic              sample_valid;
    logic              sample_y;
    logic              mismatch;
    logic [CNT_W-1:0]  fail_count;
    logic              any_fail;
    logic [2:0]        state_dbg;

    modport master (
        output start, pat_we, pat_waddr, pat_v1, pat_v2, pat_exp, dut_y,
        input  dut_in, busy, done, pat_idx, sample_valid, sample_y,
               mismatch, fail_count, any_fail, state_dbg
    );

    modport slave (
        input  start, pat_we, pat_waddr, pat_v1, pat_v2, pat_exp, dut_y,
        output dut_in, busy, done, pat_idx, sample_valid, sample_y,
               mismatch, fail_count, any_fail, state_dbg
    );
endinterface

// File: rtl/atpg_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// atpg_pattern_sequencer
//   Replays stored two-vector transition-fault patterns into injection_module.
//   Per pattern: hold V1 for HOLD_CYC cycles, apply V2 for SETTLE_CYC cycles,
//   keep V2 for one sample cycle, then capture dut_y and compare it with the
//   expected response. A run walks patterns 0..N_PAT-1 back to back.
//
//   Ports
//     clk    rising-edge system clock
//     rst_n  synchronous active-low reset (pattern memory is kept)
//     bus    atpg_pattern_sequencer_if.slave (see interface header)
//
//   Handshake: there is no backpressure anywhere. start is a request that is
//   accepted on any rising edge where the sequencer is IDLE or DONE and is
//   otherwise ignored; sample_valid is a pure one-cycle strobe qualifying
//   sample_y/mismatch and the consumer must take it in that cycle; pattern
//   writes complete at the edge where pat_we is high and the sequencer is not
//   busy, and a write coinciding with an accepted start lands first.
// ---------------------------------------------------------------------------
module atpg_pattern_sequencer #(
    parameter int N_PAT      = 4,
    parameter int IN_W       = 4,
    parameter int PAT_AW     = 2,
    parameter int HOLD_CYC   = 8,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    atpg_pattern_sequencer_if.slave bus
);
    localparam int MAX_CYC = (HOLD_CYC > SETTLE_CYC) ? HOLD_CYC : SETTLE_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int DEPTH   = 1 << PAT_AW;

    localparam logic [CW-1:0]     HOLD_LAST   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]     SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [PAT_AW-1:0] LAST_IDX    = PAT_AW'(N_PAT - 1);
    localparam logic [PAT_AW:0]   N_PAT_EXT   = (PAT_AW + 1)'(N_PAT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_V1   = 3'd1,
        S_V2   = 3'd2,
        S_SAMP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    // cur_idx steers memory reads; pat_idx is its one-cycle-late copy so the
    // consumer still sees the sampled index during the sample strobe.
    logic [PAT_AW-1:0] cur_idx, cur_idx_next;

    logic [IN_W-1:0]   dut_in_next;
    logic              busy_next, done_next;
    logic [PAT_AW-1:0] pat_idx_next;
    logic              sv_next, sy_next, mm_next;
    logic [CNT_W-1:0]  fc_next;

    // Pattern memory, sized to the full address space so every index is legal.
    logic [IN_W-1:0] v1_mem  [DEPTH];
    logic [IN_W-1:0] v2_mem  [DEPTH];
    logic            exp_mem [DEPTH];

    logic            idle_like;
    logic            wr_en;
    logic [IN_W-1:0] v1_first;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign wr_en     = bus.pat_we && idle_like && ({1'b0, bus.pat_waddr} < N_PAT_EXT);

    // A write to pattern 0 in the start cycle must reach the first V1 vector,
    // so forward the write data instead of the stale memory word.
    assign v1_first = (wr_en && (bus.pat_waddr == '0)) ? bus.pat_v1 : v1_mem[0];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            v1_mem[bus.pat_waddr]  <= bus.pat_v1;
            v2_mem[bus.pat_waddr]  <= bus.pat_v2;
            exp_mem[bus.pat_waddr] <= bus.pat_exp;
        end
    end

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        cur_idx_next = cur_idx;
        dut_in_next  = bus.dut_in;
        busy_next    = bus.busy;
        done_next    = bus.done;
        pat_idx_next = cur_idx;
        sv_next      = 1'b0;
        sy_next      = bus.sample_y;
        mm_next      = bus.mismatch;
        fc_next      = bus.fail_count;

        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_next   = S_V1;
                    cnt_next     = '0;
                    cur_idx_next = '0;
                    pat_idx_next = '0;
                    dut_in_next  = v1_first;
                    busy_next    = 1'b1;
                    done_next    = 1'b0;
                    fc_next      = '0;
                end
            end
            S_V1: begin
                if (cnt == HOLD_LAST) begin
                    state_next  = S_V2;
                    cnt_next    = '0;
                    dut_in_next = v2_mem[cur_idx];
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_V2: begin
                if (cnt == SETTLE_LAST) begin
                    state_next = S_SAMP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            S_SAMP: begin
                sv_next = 1'b1;
                sy_next = bus.dut_y;
                mm_next = bus.dut_y ^ exp_mem[cur_idx];
                if (bus.dut_y ^ exp_mem[cur_idx]) begin
                    fc_next = bus.fail_count + CNT_W'(1);
                end
                if (cur_idx != LAST_IDX) begin
                    // Next pattern's V1 lands in the same cycle as the strobe.
                    state_next   = S_V1;
                    cur_idx_next = cur_idx + PAT_AW'(1);
                    dut_in_next  = v1_mem[cur_idx + PAT_AW'(1)];
                end else begin
                    state_next  = S_DONE;
                    busy_next   = 1'b0;
                    done_next   = 1'b1;
                    dut_in_next = '0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            cnt              <= '0;
            cur_idx          <= '0;
            bus.dut_in       <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.pat_idx      <= '0;
            bus.sample_valid <= 1'b0;
            bus.sample_y     <= 1'b0;
            bus.mismatch     <= 1'b0;
            bus.fail_count   <= '0;
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            cur_idx          <= cur_idx_next;
            bus.dut_in       <= dut_in_next;
            bus.busy         <= busy_next;
            bus.done         <= done_next;
            bus.pat_idx      <= pat_idx_next;
            bus.sample_valid <= sv_next;
            bus.sample_y     <= sy_next;
            bus.mismatch     <= mm_next;
            bus.fail_count   <= fc_next;
        end
    end

    assign bus.any_fail  = (bus.fail_count != '0);
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_atpg_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_atpg_pattern_sequencer
//   Drives the default-parameter sequencer plus a minimal (1 pattern, 1/1
//   cycles) instance. The injection_module is stubbed as y = b = dut_in[2].
//   Expected waveforms are derived from the pattern timing rules: pattern i
//   owns cycles i*P+1 .. i*P+P after start (P = HOLD+SETTLE+1), V1 for the
//   first HOLD cycles, V2 for the rest, strobe one cycle after the pattern.
// ---------------------------------------------------------------------------
module tb_atpg_pattern_sequencer;
    localparam int N_PAT  = 4;
    localparam int IN_W   = 4;
    localparam int PAT_AW = 2;
    localparam int HOLD   = 8;
    localparam int SETTLE = 1;
    localparam int CNT_W  = 3;
    localparam int P      = HOLD + SETTLE + 1;
    localparam int RUN    = N_PAT * P;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    atpg_pattern_sequencer_if #(.IN_W(IN_W), .PAT_AW(PAT_AW), .CNT_W(CNT_W)) bus ();
    atpg_pattern_sequencer #(
        .N_PAT(N_PAT), .IN_W(IN_W), .PAT_AW(PAT_AW),
        .HOLD_CYC(HOLD), .SETTLE_CYC(SETTLE), .CNT_W(CNT_W)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    assign bus.dut_y = bus.dut_in[2];

    atpg_pattern_sequencer_if #(.IN_W(IN_W), .PAT_AW(1), .CNT_W(1)) sbus ();
    atpg_pattern_sequencer #(
        .N_PAT(1), .IN_W(IN_W), .PAT_AW(1),
        .HOLD_CYC(1), .SETTLE_CYC(1), .CNT_W(1)
    ) sdut (.clk(clk), .rst_n(rst_n), .bus(sbus));
    assign sbus.dut_y = sbus.dut_in[2];

    int n_assert = 0;
    int n_fail   = 0;

    // Reference pattern store for the main instance.
    logic [IN_W-1:0] m_v1  [N_PAT];
    logic [IN_W-1:0] m_v2  [N_PAT];
    logic            m_exp [N_PAT];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pat(input int addr, input logic [3:0] v1, input logic [3:0] v2, input logic e);
        bus.pat_we    = 1'b1;
        bus.pat_waddr = addr[PAT_AW-1:0];
        bus.pat_v1    = v1;
        bus.pat_v2    = v2;
        bus.pat_exp   = e;
        tick();
        bus.pat_we = 1'b0;
        m_v1[addr]  = v1;
        m_v2[addr]  = v2;
        m_exp[addr] = e;
    endtask

    // One full run from an accepted start. disturb_cyc > 0 pulses start and a
    // write in that busy cycle; both must be ignored (model left unchanged).
    task automatic run_check(input int disturb_cyc, input bit wr_with_start);
        int fc;
        int i;
        int ph;
        int j;
        int exp_idx;
        bit strobe;
        logic y;
        logic mm;
        logic [3:0] exp_in;
        int wa;
        bus.start = 1'b1;
        if (wr_with_start) begin
            wa = $urandom_range(0, N_PAT - 1);
            bus.pat_we    = 1'b1;
            bus.pat_waddr = wa[PAT_AW-1:0];
            bus.pat_v1    = 4'($urandom);
            bus.pat_v2    = 4'($urandom);
            bus.pat_exp   = 1'($urandom);
            m_v1[wa]  = bus.pat_v1;
            m_v2[wa]  = bus.pat_v2;
            m_exp[wa] = bus.pat_exp;
        end
        tick();
        bus.start  = 1'b0;
        bus.pat_we = 1'b0;
        fc = 0;
        for (int c = 1; c <= RUN + 1; c++) begin
            i      = (c - 1) / P;
            ph     = (c - 1) % P;
            strobe = (c > 1) && (ph == 0);
            if (strobe) begin
                j  = i - 1;
                y  = m_v2[j][2];
                mm = y ^ m_exp[j];
                if (mm) fc++;
                check("sample_y", 32'(bus.sample_y), 32'(y));
                check("mismatch", 32'(bus.mismatch), 32'(mm));
            end
            if (c <= RUN) exp_in = (ph < HOLD) ? m_v1[i] : m_v2[i];
            else          exp_in = 4'b0000;
            exp_idx = strobe ? i - 1 : i;
            check("dut_in", 32'(bus.dut_in), 32'(exp_in));
            check("busy", 32'(bus.busy), (c <= RUN) ? 32'd1 : 32'd0);
            check("done", 32'(bus.done), (c > RUN) ? 32'd1 : 32'd0);
            check("sample_valid", 32'(bus.sample_valid), 32'(strobe));
            check("pat_idx", 32'(bus.pat_idx), 32'(exp_idx));
            check("fail_count", 32'(bus.fail_count), 32'(fc));
            check("any_fail", 32'(bus.any_fail), (fc != 0) ? 32'd1 : 32'd0);
            if (c == disturb_cyc) begin
                bus.start     = 1'b1;
                bus.pat_we    = 1'b1;
                bus.pat_waddr = PAT_AW'($urandom_range(0, N_PAT - 1));
                bus.pat_v1    = 4'($urandom);
                bus.pat_v2    = 4'($urandom);
                bus.pat_exp   = 1'($urandom);
            end
            tick();
            bus.start  = 1'b0;
            bus.pat_we = 1'b0;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.pat_we = 1'b0; bus.pat_waddr = '0;
        bus.pat_v1 = '0; bus.pat_v2 = '0; bus.pat_exp = 1'b0;
        sbus.start = 1'b0; sbus.pat_we = 1'b0; sbus.pat_waddr = '0;
        sbus.pat_v1 = '0; sbus.pat_v2 = '0; sbus.pat_exp = 1'b0;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_dut_in", 32'(bus.dut_in), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_pat_idx", 32'(bus.pat_idx), 32'd0);
        check("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
        check("rst_sample_y", 32'(bus.sample_y), 32'd0);
        check("rst_mismatch", 32'(bus.mismatch), 32'd0);
        check("rst_fail_count", 32'(bus.fail_count), 32'd0);
        check("rst_any_fail", 32'(bus.any_fail), 32'd0);
        check("rst_small_dut_in", 32'(sbus.dut_in), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed patterns: clean run, then p2 expecting 1 (one mismatch),
        // then restore p2 and restart from DONE (fail_count must clear).
        write_pat(0, 4'b0001, 4'b0110, 1'b1);
        write_pat(1, 4'b0000, 4'b0111, 1'b1);
        write_pat(2, 4'b0001, 4'b0000, 1'b0);
        write_pat(3, 4'b0110, 4'b0001, 1'b0);
        run_check(0, 1'b0);
        write_pat(2, 4'b0001, 4'b0000, 1'b1);
        run_check(0, 1'b0);
        write_pat(2, 4'b0001, 4'b0000, 1'b0);
        run_check(0, 1'b0);

        // Reset during p1 V2 (cycle P+HOLD+1 after start).
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (P + HOLD) tick();
        check("pre_rst_dut_in", 32'(bus.dut_in), 32'(m_v2[1]));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_dut_in", 32'(bus.dut_in), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_fail_count", 32'(bus.fail_count), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_pat_idx", 32'(bus.pat_idx), 32'd0);
        tick();
        run_check(0, 1'b0);

        // Start and writes while busy are ignored; the following runs use the
        // model's unchanged memory image.
        run_check(5, 1'b0);
        run_check(RUN - 3, 1'b0);
        run_check(0, 1'b0);

        // Randomized patterns with writes coinciding with start.
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < N_PAT; a++) begin
                write_pat(a, 4'($urandom), 4'($urandom), 1'($urandom));
            end
            run_check($urandom_range(2, RUN - 1), 1'b1);
        end

        // Minimal instance: 3-cycle run, single strobe, done in cycle 4.
        sbus.pat_we = 1'b1; sbus.pat_waddr = 1'b0;
        sbus.pat_v1 = 4'b1010; sbus.pat_v2 = 4'b0100; sbus.pat_exp = 1'b0;
        tick();
        sbus.pat_waddr = 1'b1;
        sbus.pat_v1 = 4'b1111; sbus.pat_v2 = 4'b0000; sbus.pat_exp = 1'b1;
        tick();
        sbus.pat_we = 1'b0;
        sbus.start = 1'b1;
        tick();
        sbus.start = 1'b0;
        check("s_c1_dut_in", 32'(sbus.dut_in), 32'hA);
        check("s_c1_busy", 32'(sbus.busy), 32'd1);
        tick();
        check("s_c2_dut_in", 32'(sbus.dut_in), 32'h4);
        tick();
        check("s_c3_dut_in", 32'(sbus.dut_in), 32'h4);
        check("s_c3_sample_valid", 32'(sbus.sample_valid), 32'd0);
        tick();
        check("s_c4_sample_valid", 32'(sbus.sample_valid), 32'd1);
        check("s_c4_sample_y", 32'(sbus.sample_y), 32'd1);
        check("s_c4_mismatch", 32'(sbus.mismatch), 32'd1);
        check("s_c4_fail_count", 32'(sbus.fail_count), 32'd1);
        check("s_c4_any_fail", 32'(sbus.any_fail), 32'd1);
        check("s_c4_done", 32'(sbus.done), 32'd1);
        check("s_c4_busy", 32'(sbus.busy), 32'd0);
        check("s_c4_dut_in", 32'(sbus.dut_in), 32'd0);
        check("s_c4_pat_idx", 32'(sbus.pat_idx), 32'd0);
        tick();
        check("s_c5_sample_valid", 32'(sbus.sample_valid), 32'd0);
        check("s_c5_sample_y_held", 32'(sbus.sample_y), 32'd1);
        check("s_c5_done_held", 32'(sbus.done), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
